// File: rtl/spi_dac_mch_writer.sv
// Multi-channel SPI DAC writer: one mode-0, MSB-first frame per masked channel, lowest index first.
// Optional build macro SPI_DAC_LDAC_EN adds an ldac_o strobe (LDAC state) after the last frame.
module spi_dac_mch_writer #(
  parameter int DATA_W  = 24,
  parameter int N_CH    = 4,
  parameter int CLK_DIV = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     strw_i,
  input  logic [N_CH*DATA_W-1:0]   data_i,
  input  logic [N_CH-1:0]          ch_mask_i,
  output logic                     cs_o,
  output logic                     sck_o,
  output logic                     mosi_o,
  output logic                     busy_o,
`ifdef SPI_DAC_LDAC_EN
  output logic                     ldac_o,
`endif
  output logic                     eow_o
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_LOAD    = 4'd1;
  localparam logic [3:0] ST_SETUP   = 4'd2;
  localparam logic [3:0] ST_SCK_HI  = 4'd3;
  localparam logic [3:0] ST_SCK_LO  = 4'd4;
  localparam logic [3:0] ST_CS_HOLD = 4'd5;
  localparam logic [3:0] ST_CS_GAP  = 4'd6;
  localparam logic [3:0] ST_DONE    = 4'd7;
`ifdef SPI_DAC_LDAC_EN
  localparam logic [3:0] ST_LDAC    = 4'd8;
`endif

  // Lowest-index set bit of a channel mask (0 when the mask is empty)
  function automatic logic [CH_W-1:0] lowest_ch(input logic [N_CH-1:0] m);
    lowest_ch = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (m[k]) lowest_ch = CH_W'(k);
    end
  endfunction

  logic [3:0]             state_r, state_s;
  logic [7:0]             cnt_r, cnt_s;
  logic [BIT_W-1:0]       bit_r, bit_s;
  logic [DATA_W-1:0]      shift_r, shift_s;
  logic [N_CH*DATA_W-1:0] data_r, data_s;
  logic [N_CH-1:0]        pending_r, pending_s;

  logic                   timeout_s;
  logic [N_CH-1:0]        src_mask_s;
  logic [N_CH*DATA_W-1:0] data_src_s;
  logic [CH_W-1:0]        sel_s;
  logic [DATA_W-1:0]      word_s;
  logic                   enter_setup_s, enter_lo_s, frame_s;

  // Next-state decode; every timed state lasts CLK_DIV cycles
  always_comb begin
    state_s   = state_r;
    timeout_s = (cnt_r == DIV_LAST);
    case (state_r)
      ST_IDLE: begin
        if (strw_i) state_s = ST_LOAD;
        else        state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (ch_mask_i == '0) state_s = ST_DONE;
        else                 state_s = ST_SETUP;
      end
      ST_SETUP: begin
        if (timeout_s) state_s = ST_SCK_HI;
        else           state_s = ST_SETUP;
      end
      ST_SCK_HI: begin
        if (!timeout_s)            state_s = ST_SCK_HI;
        else if (bit_r == BIT_LAST) state_s = ST_CS_HOLD;
        else                        state_s = ST_SCK_LO;
      end
      ST_SCK_LO: begin
        if (timeout_s) state_s = ST_SCK_HI;
        else           state_s = ST_SCK_LO;
      end
      ST_CS_HOLD: begin
        if (timeout_s) state_s = ST_CS_GAP;
        else           state_s = ST_CS_HOLD;
      end
      ST_CS_GAP: begin
        if (!timeout_s)           state_s = ST_CS_GAP;
        else if (pending_r != '0) state_s = ST_SETUP;
`ifdef SPI_DAC_LDAC_EN
        else                      state_s = ST_LDAC;
`else
        else                      state_s = ST_DONE;
`endif
      end
`ifdef SPI_DAC_LDAC_EN
      ST_LDAC: begin
        if (timeout_s) state_s = ST_DONE;
        else           state_s = ST_LDAC;
      end
`endif
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath next values: channel select, word load, shift and bit count
  always_comb begin
    // LOAD works straight from the inputs since they are latched on the same edge
    if (state_r == ST_LOAD) begin
      src_mask_s = ch_mask_i;
      data_src_s = data_i;
      data_s     = data_i;
    end else begin
      src_mask_s = pending_r;
      data_src_s = data_r;
      data_s     = data_r;
    end
    sel_s         = lowest_ch(src_mask_s);
    word_s        = data_src_s[int'(sel_s) * DATA_W +: DATA_W];
    enter_setup_s = (state_s == ST_SETUP)  && (state_r != ST_SETUP);
    enter_lo_s    = (state_s == ST_SCK_LO) && (state_r != ST_SCK_LO);
    frame_s       = (state_s == ST_SETUP)  || (state_s == ST_SCK_HI) ||
                    (state_s == ST_SCK_LO) || (state_s == ST_CS_HOLD);
    if (enter_setup_s) begin
      shift_s   = word_s;
      bit_s     = '0;
      pending_s = src_mask_s & ~(N_CH'(1) << sel_s);
    end else if (enter_lo_s) begin
      shift_s   = {shift_r[DATA_W-2:0], 1'b0};
      bit_s     = bit_r + BIT_W'(1);
      pending_s = pending_r;
    end else begin
      shift_s   = shift_r;
      bit_s     = bit_r;
      pending_s = pending_r;
    end
    if ((state_s == state_r) && (state_r != ST_IDLE)) cnt_s = cnt_r + 8'd1;
    else                                               cnt_s = 8'd0;
  end

  // State, datapath and outputs; outputs registered from the next state so they align with it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      bit_r     <= '0;
      shift_r   <= '0;
      data_r    <= '0;
      pending_r <= '0;
      cs_o      <= 1'b1;
      sck_o     <= 1'b0;
      mosi_o    <= 1'b0;
      busy_o    <= 1'b0;
      eow_o     <= 1'b0;
`ifdef SPI_DAC_LDAC_EN
      ldac_o    <= 1'b1;
`endif
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_r     <= bit_s;
      shift_r   <= shift_s;
      data_r    <= data_s;
      pending_r <= pending_s;
      cs_o      <= ~frame_s;
      sck_o     <= (state_s == ST_SCK_HI);
      mosi_o    <= frame_s & shift_s[DATA_W-1];
      busy_o    <= (state_s != ST_IDLE);
      eow_o     <= (state_s == ST_DONE);
`ifdef SPI_DAC_LDAC_EN
      ldac_o    <= (state_s != ST_LDAC);
`endif
    end
  end

endmodule

// File: tb/tb_spi_dac_mch_writer.sv
// Directed bench for spi_dac_mch_writer: table of transfers plus reset, busy-strobe and CLK_DIV=1 sequences.
module tb_spi_dac_mch_writer;

  localparam int DW = 8;
  localparam int NCH = 4;
  localparam int CD = 2;
  localparam int FRAME = CD * (2 * DW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic strw = 1'b0;
  logic [NCH*DW-1:0] data = '0;
  logic [NCH-1:0] mask = '0;
  logic cs, sck, mosi, busy, eow;
  logic strw2 = 1'b0;
  logic [7:0] data2 = 8'hC3;
  logic [0:0] mask2 = 1'b1;
  logic cs2, sck2, mosi2, busy2, eow2;
`ifdef SPI_DAC_LDAC_EN
  logic ldac, ldac2;
`endif

  spi_dac_mch_writer #(.DATA_W(DW), .N_CH(NCH), .CLK_DIV(CD)) u_dut (
    .clk_i(clk), .rst_i(rst), .strw_i(strw), .data_i(data), .ch_mask_i(mask),
    .cs_o(cs), .sck_o(sck), .mosi_o(mosi), .busy_o(busy),
`ifdef SPI_DAC_LDAC_EN
    .ldac_o(ldac),
`endif
    .eow_o(eow));

  spi_dac_mch_writer #(.DATA_W(8), .N_CH(1), .CLK_DIV(1)) u_fast (
    .clk_i(clk), .rst_i(rst), .strw_i(strw2), .data_i(data2), .ch_mask_i(mask2),
    .cs_o(cs2), .sck_o(sck2), .mosi_o(mosi2), .busy_o(busy2),
`ifdef SPI_DAC_LDAC_EN
    .ldac_o(ldac2),
`endif
    .eow_o(eow2));

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          nfr;
    logic [31:0] words;
    int          busy;
  } vec_t;

  vec_t vt[5];
  int total = 0;
  int bad = 0;

  // bus monitor state
  int eow_n, busy_n, fall_n, edges, cs_len, gap_len;
  logic [7:0] sh;
  logic prev_sck = 1'b0, prev_cs = 1'b1;
  logic [7:0] wq[$];
  int lq[$], eq[$], gq[$];
  int f_cs, f_edges, f_eow, f_busy;
  logic [7:0] f_sh;
  logic f_prev_sck = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    eow_n = 0; busy_n = 0; fall_n = 0; edges = 0; cs_len = 0; gap_len = 0; sh = 8'h00;
    wq.delete(); lq.delete(); eq.delete(); gq.delete();
    f_cs = 0; f_edges = 0; f_eow = 0; f_busy = 0; f_sh = 8'h00;
  endtask

  task automatic sample();
    if (!cs) cs_len++;
    if (cs && busy) gap_len++;
    if (!cs && prev_cs) begin
      fall_n++;
      if (wq.size() > 0) gq.push_back(gap_len);
      gap_len = 0;
    end
    if (sck && !prev_sck) begin
      sh = {sh[6:0], mosi};
      edges++;
    end
    if (cs && !prev_cs) begin
      wq.push_back(sh); lq.push_back(cs_len); eq.push_back(edges);
      cs_len = 0; edges = 0;
    end
    if (eow) eow_n++;
    if (busy) busy_n++;
    prev_sck = sck; prev_cs = cs;
    if (!cs2) f_cs++;
    if (sck2 && !f_prev_sck) begin
      f_sh = {f_sh[6:0], mosi2};
      f_edges++;
    end
    if (eow2) f_eow++;
    if (busy2) f_busy++;
    f_prev_sck = sck2;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  // one transfer; at loop index disturb the inputs are scrambled and strw pulsed again
  task automatic run_xfer(input logic [3:0] m, input logic [31:0] d, input int disturb);
    clear_stats();
    data = d; mask = m; strw = 1'b1;
    tick();
    strw = 1'b0;
    for (int i = 0; i < 3000 && eow_n == 0; i++) begin
      if (i == disturb) begin
        data = 32'hFFFF_FFFF; mask = 4'hF; strw = 1'b1;
      end
      tick();
      strw = 1'b0;
    end
    chk("eow_seen", 32'(eow_n > 0), 32'd1);
    repeat (4) tick();
  endtask

  task automatic check_vec(input vec_t v, input int id);
    logic [31:0] w;
    w = v.words;
    chk($sformatf("v%0d_frames", id), 32'(wq.size()), 32'(v.nfr));
    chk($sformatf("v%0d_cs_falls", id), 32'(fall_n), 32'(v.nfr));
    for (int j = 0; j < v.nfr && j < wq.size(); j++) begin
      chk($sformatf("v%0d_word%0d", id, j), 32'(wq[j]), 32'(w[j*8 +: 8]));
      chk($sformatf("v%0d_cslen%0d", id, j), 32'(lq[j]), 32'(FRAME));
      chk($sformatf("v%0d_edges%0d", id, j), 32'(eq[j]), 32'(DW));
    end
    if (v.nfr > 1) begin
      chk($sformatf("v%0d_ngaps", id), 32'(gq.size()), 32'(v.nfr - 1));
      for (int j = 0; j < gq.size(); j++)
        chk($sformatf("v%0d_gap%0d", id, j), 32'(gq[j]), 32'(CD));
    end
    chk($sformatf("v%0d_eow", id), 32'(eow_n), 32'd1);
    chk($sformatf("v%0d_busy", id), 32'(busy_n), 32'(v.busy));
    chk($sformatf("v%0d_idle_pins", id), {29'd0, cs, sck, mosi}, 32'b100);
  endtask

  initial begin
    vec_t vb;
    vt[0] = '{mask: 4'b0001, data: 32'h4433_22A5, nfr: 1, words: 32'h0000_00A5, busy: 38};
    vt[1] = '{mask: 4'b1010, data: 32'h4433_2211, nfr: 2, words: 32'h0000_4422, busy: 74};
    vt[2] = '{mask: 4'b0000, data: 32'h1234_5678, nfr: 0, words: 32'h0000_0000, busy: 2};
    vt[3] = '{mask: 4'b1111, data: 32'h3CFF_8001, nfr: 4, words: 32'h3CFF_8001, busy: 146};
    vt[4] = '{mask: 4'b1000, data: 32'h5A00_0000, nfr: 1, words: 32'h0000_005A, busy: 38};
    clear_stats();

    repeat (2) tick();
    chk("rst_pins", {27'd0, cs, sck, mosi, busy, eow}, 32'b10000);
    chk("rst_pins_fast", {27'd0, cs2, sck2, mosi2, busy2, eow2}, 32'b10000);
    rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 5; i++) begin
      run_xfer(vt[i].mask, vt[i].data, -1);
      check_vec(vt[i], i);
    end

    // strobe and new data while busy must not disturb the running transfer
    vb = '{mask: 4'b0011, data: 32'h0000_6996, nfr: 2, words: 32'h0000_6996, busy: 74};
    run_xfer(vb.mask, vb.data, 20);
    check_vec(vb, 5);
    clear_stats();
    repeat (60) tick();
    chk("busy_strobe_no_second", 32'(fall_n + busy_n), 32'd0);

    // reset after the third SCK rising edge
    clear_stats();
    data = 32'h0000_00A5; mask = 4'b0001; strw = 1'b1;
    tick();
    strw = 1'b0;
    for (int i = 0; i < 200 && edges < 3; i++) tick();
    chk("rst_mid_edges", 32'(edges), 32'd3);
    rst = 1'b1;
    #1;
    chk("rst_mid_pins", {30'd0, cs, sck}, 32'b10);
    repeat (3) tick();
    chk("rst_mid_state", {29'd0, busy, mosi, eow}, 32'b000);
    chk("rst_mid_no_eow", 32'(eow_n), 32'd0);
    rst = 1'b0;
    clear_stats();
    repeat (40) tick();
    chk("rst_no_restart", 32'(fall_n + busy_n), 32'd0);
    run_xfer(vt[0].mask, vt[0].data, -1);
    check_vec(vt[0], 6);

    // CLK_DIV=1 instance: every timed state is a single cycle
    clear_stats();
    strw2 = 1'b1;
    tick();
    strw2 = 1'b0;
    repeat (40) tick();
    chk("fast_cs_len", 32'(f_cs), 32'd17);
    chk("fast_edges", 32'(f_edges), 32'd8);
    chk("fast_word", 32'(f_sh), 32'h0000_00C3);
    chk("fast_eow", 32'(f_eow), 32'd1);
    chk("fast_busy", 32'(f_busy), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
